// File: rtl/red_pitaya_pwm_mc.sv
// red_pitaya_pwm_mc: multi-channel PWM, double-buffered config, frame sync.
// Define PWM_SIGDELTA_EN to dither the fractional duty across periods.
module red_pitaya_pwm_mc #(
  parameter int CHN  = 4,
  parameter int IW   = 8,
  parameter int FW   = 16,
  parameter int FRM  = 16,
  parameter int FULL = 156
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [IW-1:0]          cfg_full,
  input  logic [CHN*(IW+FW)-1:0] cfg_dat,
  input  logic                   cfg_we,
  output logic                   cfg_pend,
  output logic [CHN-1:0]         pwm_o,
  output logic                   pwm_s
);

  localparam int DW = IW + FW;
  localparam int BW = (FRM > 1) ? $clog2(FRM) : 1;
  localparam logic [BW-1:0] BLAST = BW'(FRM - 1);
  localparam logic [IW-1:0] FULL_R = IW'(FULL);
  localparam logic [IW-1:0] DMAX = '1;

  logic [IW-1:0]     vcnt_q, vcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [IW-1:0]     full_q, full_d;
  logic [IW-1:0]     pfull_q, pfull_d;
  logic [CHN*DW-1:0] pdat_q, pdat_d;
  logic [CHN*DW-1:0] adat_q, adat_d;
  logic              pend_q, pend_d;
  logic [CHN*IW-1:0] duty_q, duty_d;
  logic [CHN-1:0]    pwm_q, pwm_d;
  logic              sync_q, sync_d;

  logic              pe;
  logic              fe;
  logic              apply;
  logic [CHN*DW-1:0] nxt;
  logic [IW:0]       dsum;
  logic              carry;

`ifdef PWM_SIGDELTA_EN
  logic [CHN*FW-1:0] acc_q, acc_d;
  logic [FW:0]       asum;
`else
  logic [CHN*FW-1:0] frac_all;
  logic              unused_frac;
  assign unused_frac = ^frac_all;
`endif

  // period/frame counters, pending buffer capture and frame-end apply
  always_comb begin
    pe      = (vcnt_q == full_q);
    fe      = pe && (bcnt_q == BLAST);
    apply   = fe && pend_q;
    vcnt_d  = pe ? IW'(1) : vcnt_q + IW'(1);
    bcnt_d  = pe ? bcnt_q + BW'(1) : bcnt_q;
    full_d  = full_q;
    adat_d  = adat_q;
    pfull_d = pfull_q;
    pdat_d  = pdat_q;
    pend_d  = pend_q;
    if (apply) begin
      full_d = (pfull_q < IW'(2)) ? IW'(2) : pfull_q;
      adat_d = pdat_q;
      pend_d = 1'b0;
    end
    if (cfg_we) begin
      pfull_d = cfg_full;
      pdat_d  = cfg_dat;
      pend_d  = 1'b1;
    end
    nxt    = apply ? pdat_q : adat_q;
    sync_d = (bcnt_q == BLAST) && (vcnt_q == full_q - IW'(1));
  end

  // per-channel duty for the coming period and PWM compare
  always_comb begin
    duty_d = duty_q;
    pwm_d  = '0;
    carry  = 1'b0;
    dsum   = '0;
`ifdef PWM_SIGDELTA_EN
    acc_d  = acc_q;
    asum   = '0;
`else
    frac_all = '0;
`endif
    for (int n = 0; n < CHN; n++) begin
      carry = 1'b0;
`ifdef PWM_SIGDELTA_EN
      asum = {1'b0, acc_q[n*FW +: FW]}
           + {1'b0, nxt[n*DW +: FW]};
      if (pe) begin
        acc_d[n*FW +: FW] = asum[FW-1:0];
        carry = asum[FW];
      end
`else
      frac_all[n*FW +: FW] = nxt[n*DW +: FW];
`endif
      dsum = {1'b0, nxt[n*DW+FW +: IW]}
           + {{IW{1'b0}}, carry};
      if (pe) begin
        duty_d[n*IW +: IW] = dsum[IW] ? DMAX : dsum[IW-1:0];
      end
      pwm_d[n] = (vcnt_q != '0)
              && (vcnt_q <= duty_q[n*IW +: IW]);
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vcnt_q  <= '0;
      bcnt_q  <= '0;
      full_q  <= FULL_R;
      pfull_q <= '0;
      pdat_q  <= '0;
      adat_q  <= '0;
      pend_q  <= 1'b0;
      duty_q  <= '0;
      pwm_q   <= '0;
      sync_q  <= 1'b0;
`ifdef PWM_SIGDELTA_EN
      acc_q   <= '0;
`endif
    end else begin
      vcnt_q  <= vcnt_d;
      bcnt_q  <= bcnt_d;
      full_q  <= full_d;
      pfull_q <= pfull_d;
      pdat_q  <= pdat_d;
      adat_q  <= adat_d;
      pend_q  <= pend_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      sync_q  <= sync_d;
`ifdef PWM_SIGDELTA_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign pwm_o    = pwm_q;
  assign pwm_s    = sync_q;
  assign cfg_pend = pend_q;

endmodule

// File: tb/tb_red_pitaya_pwm_mc.sv
// tb_red_pitaya_pwm_mc: scoreboard bench for the multi-channel PWM.
// Per-period high counts are predicted from the configured duties.
module tb_red_pitaya_pwm_mc;

  localparam int CHN  = 4;
  localparam int IW   = 8;
  localparam int FW   = 16;
  localparam int DW   = IW + FW;
  localparam int FRM  = 16;
  localparam int FULL = 156;
  localparam int LIM  = 6000;

  typedef int arr_t [CHN];

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [IW-1:0]        cfg_full = '0;
  logic [CHN*DW-1:0]    cfg_dat = '0;
  logic                 cfg_we = 1'b0;
  logic                 cfg_pend;
  logic [CHN-1:0]       pwm_o;
  logic                 pwm_s;

  int total = 0;
  int bad = 0;
  int sb[$];
  int obs[$];
  int macc[CHN];

  red_pitaya_pwm_mc #(
    .CHN(CHN), .IW(IW), .FW(FW), .FRM(FRM), .FULL(FULL)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cfg_full(cfg_full),
    .cfg_dat(cfg_dat),
    .cfg_we(cfg_we),
    .cfg_pend(cfg_pend),
    .pwm_o(pwm_o),
    .pwm_s(pwm_s)
  );

  always #5 clk = ~clk;

  // called at a negedge; strobe is captured by the following posedge
  task automatic write_cfg(input int full, input arr_t ii, input arr_t ff);
    cfg_full = full[IW-1:0];
    for (int n = 0; n < CHN; n++)
      cfg_dat[n*DW +: DW] = {ii[n][IW-1:0], ff[n][FW-1:0]};
    cfg_we = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_sync(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pwm_s !== 1'b1 && n < LIM);
    if (pwm_s !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL sync_timeout waited=%0d want=pwm_s pulse", n);
      n = -1;
    end
  endtask

  // reference model: expected high count per period and channel
  function automatic void push_exp(int np, int full, arr_t ii, arr_t ff);
    int d;
    int c;
    int s;
    for (int p = 0; p < np; p++) begin
      for (int n = 0; n < CHN; n++) begin
        c = 0;
        s = macc[n] + ff[n];
`ifdef PWM_SIGDELTA_EN
        c = s >> FW;
        macc[n] = s & ((1 << FW) - 1);
`else
        macc[n] = 0;
        if (s < 0) c = 0;
`endif
        d = ii[n] + c;
        if (d > (1 << IW) - 1) d = (1 << IW) - 1;
        sb.push_back((d < full) ? d : full);
      end
    end
  endfunction

  // caller sits at the negedge one cycle after the period boundary
  task automatic measure(input int full, input int np);
    int cnt [CHN];
    for (int p = 0; p < np; p++) begin
      for (int n = 0; n < CHN; n++) cnt[n] = 0;
      for (int k = 0; k < full; k++) begin
        @(negedge clk);
        for (int n = 0; n < CHN; n++)
          if (pwm_o[n] === 1'b1) cnt[n]++;
      end
      for (int n = 0; n < CHN; n++) obs.push_back(cnt[n]);
    end
  endtask

  task automatic test_reset();
    int n;
    bit hi;
    cfg_we = 1'b1;
    cfg_full = 8'd3;
    cfg_dat = '1;
    repeat (10) @(negedge clk);
    total++;
    if (pwm_o !== '0) begin
      bad++; $display("FAIL rst_pwm_o got=%b want=0", pwm_o);
    end
    total++;
    if (pwm_s !== 1'b0) begin
      bad++; $display("FAIL rst_pwm_s got=%b want=0", pwm_s);
    end
    total++;
    if (cfg_pend !== 1'b0) begin
      bad++; $display("FAIL rst_pend got=%b want=0", cfg_pend);
    end
    cfg_we = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < CHN; i++) macc[i] = 0;
    n = 0;
    hi = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (pwm_o !== '0) hi = 1'b1;
    end while (pwm_s !== 1'b1 && n < LIM);
    total++;
    if (n !== FRM * FULL) begin
      bad++; $display("FAIL rst_first_sync got=%0d want=%0d", n, FRM * FULL);
    end
    total++;
    if (hi !== 1'b0 || cfg_pend !== 1'b0) begin
      bad++; $display("FAIL rst_idle got=%b/%b want=0/0", hi, cfg_pend);
    end
  endtask

  task automatic test_duty_edges();
    int n, got, want, k;
    arr_t ii, zr;
    ii = '{0, 78, 156, 255};
    zr = '{0, 0, 0, 0};
    write_cfg(FULL, ii, zr);
    total++;
    if (cfg_pend !== 1'b1) begin
      bad++; $display("FAIL t2_pend got=%b want=1", cfg_pend);
    end
    push_exp(2, FULL, ii, zr);
    wait_sync(n);
    @(negedge clk);
    measure(FULL, 2);
    k = 0;
    while (obs.size() > 0) begin
      got = obs.pop_front();
      want = (sb.size() > 0) ? sb.pop_front() : -1;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL t2_high idx=%0d got=%0d want=%0d", k, got, want);
      end
      k++;
    end
    total++;
    if (cfg_pend !== 1'b0) begin
      bad++; $display("FAIL t2_pend_clr got=%b want=0", cfg_pend);
    end
  endtask

  task automatic test_double_buffer();
    int n, got, want, k;
    arr_t a, b, c, zr;
    a = '{10, 0, 0, 0};
    b = '{100, 0, 0, 0};
    c = '{40, 0, 0, 0};
    zr = '{0, 0, 0, 0};
    wait_sync(n);
    write_cfg(FULL, a, zr);
    wait_sync(n);
    @(negedge clk);
    push_exp(4, FULL, a, zr);
    measure(FULL, 4);
    write_cfg(FULL, b, zr);
    total++;
    if (cfg_pend !== 1'b1) begin
      bad++; $display("FAIL t3_mid_pend got=%b want=1", cfg_pend);
    end
    push_exp(FRM - 4, FULL, a, zr);
    push_exp(2, FULL, b, zr);
    measure(FULL, FRM - 2);
    k = 0;
    while (obs.size() > 0) begin
      got = obs.pop_front();
      want = (sb.size() > 0) ? sb.pop_front() : -1;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL t3_mid_high idx=%0d got=%0d want=%0d", k, got, want);
      end
      k++;
    end
    total++;
    if (cfg_pend !== 1'b0) begin
      bad++; $display("FAIL t3_mid_applied got=%b want=0", cfg_pend);
    end
    wait_sync(n);
    write_cfg(FULL, c, zr);
    total++;
    if (cfg_pend !== 1'b1) begin
      bad++; $display("FAIL t3_fe_pend got=%b want=1", cfg_pend);
    end
    push_exp(1, FULL, b, zr);
    @(negedge clk);
    measure(FULL, 1);
    wait_sync(n);
    total++;
    if (cfg_pend !== 1'b1) begin
      bad++; $display("FAIL t3_fe_hold got=%b want=1", cfg_pend);
    end
    @(negedge clk);
    total++;
    if (cfg_pend !== 1'b0) begin
      bad++; $display("FAIL t3_fe_applied got=%b want=0", cfg_pend);
    end
    push_exp(1, FULL, c, zr);
    measure(FULL, 1);
    k = 0;
    while (obs.size() > 0) begin
      got = obs.pop_front();
      want = (sb.size() > 0) ? sb.pop_front() : -1;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL t3_fe_high idx=%0d got=%0d want=%0d", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_period();
    int n, got, want, k;
    arr_t ii, zr;
    ii = '{25, 60, 0, 1};
    zr = '{0, 0, 0, 0};
    wait_sync(n);
    write_cfg(50, ii, zr);
    wait_sync(n);
    wait_sync(n);
    total++;
    if (n !== FRM * 50) begin
      bad++; $display("FAIL t4_spacing50 got=%0d want=%0d", n, FRM * 50);
    end
    push_exp(1, 50, ii, zr);
    @(negedge clk);
    measure(50, 1);
    write_cfg(1, ii, zr);
    wait_sync(n);
    wait_sync(n);
    total++;
    if (n !== FRM * 2) begin
      bad++; $display("FAIL t4_spacing2a got=%0d want=%0d", n, FRM * 2);
    end
    wait_sync(n);
    total++;
    if (n !== FRM * 2) begin
      bad++; $display("FAIL t4_spacing2b got=%0d want=%0d", n, FRM * 2);
    end
    push_exp(2, 2, ii, zr);
    @(negedge clk);
    measure(2, 2);
    k = 0;
    while (obs.size() > 0) begin
      got = obs.pop_front();
      want = (sb.size() > 0) ? sb.pop_front() : -1;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL t4_high idx=%0d got=%0d want=%0d", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_reset_pending();
    int n, got, want, k;
    arr_t ii, zr;
    ii = '{99, 99, 99, 99};
    zr = '{0, 0, 0, 0};
    write_cfg(20, ii, zr);
    total++;
    if (cfg_pend !== 1'b1) begin
      bad++; $display("FAIL t6_pend got=%b want=1", cfg_pend);
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (cfg_pend !== 1'b0 || pwm_o !== '0) begin
      bad++; $display("FAIL t6_rst got=%b/%b want=0/0", cfg_pend, pwm_o);
    end
    rstn = 1'b1;
    for (int i = 0; i < CHN; i++) macc[i] = 0;
    wait_sync(n);
    total++;
    if (n !== FRM * FULL) begin
      bad++; $display("FAIL t6_sync got=%0d want=%0d", n, FRM * FULL);
    end
    push_exp(2, FULL, zr, zr);
    @(negedge clk);
    measure(FULL, 2);
    k = 0;
    while (obs.size() > 0) begin
      got = obs.pop_front();
      want = (sb.size() > 0) ? sb.pop_front() : -1;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL t6_high idx=%0d got=%0d want=%0d", k, got, want);
      end
      k++;
    end
  endtask

  task automatic test_sigdelta();
    int n, got, want, k;
    arr_t ii, ff;
    ii = '{10, 10, 255, 5};
    ff = '{'h8000, 'h4000, 'hFFFF, 0};
    write_cfg(255, ii, ff);
    push_exp(8, 255, ii, ff);
    wait_sync(n);
    @(negedge clk);
    measure(255, 8);
    k = 0;
    while (obs.size() > 0) begin
      got = obs.pop_front();
      want = (sb.size() > 0) ? sb.pop_front() : -1;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL t5_high idx=%0d got=%0d want=%0d", k, got, want);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_duty_edges();
    test_double_buffer();
    test_period();
    test_reset_pending();
    test_sigdelta();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
